// File: rtl/tile_scheduler_if.sv
// Host/datapath-facing bundle for tile_scheduler: descriptor push channel, active config and
// datapath controls. master = host/datapath side, slave = scheduler.
interface tile_scheduler_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DESC_DEPTH = 4
);
  localparam int unsigned DescW = 8 * ADDR_WIDTH + 2;
  localparam int unsigned CntW  = $clog2(DESC_DEPTH) + 1;

  logic [DescW-1:0] desc;
  logic             desc_valid;
  logic             desc_ready;
  logic [CntW-1:0]  desc_count;
  logic [DescW-1:0] cfg;
  logic             reg_clear;
  logic             route_en;
  logic             tile_done;
  logic             abort;
  logic             busy;
  logic             tile_pulse;
  logic [15:0]      tiles_done;
  logic             timeout;

  modport master (
    output desc, desc_valid, tile_done, abort,
    input  desc_ready, desc_count, cfg, reg_clear, route_en, busy, tile_pulse, tiles_done, timeout
  );

  modport slave (
    input  desc, desc_valid, tile_done, abort,
    output desc_ready, desc_count, cfg, reg_clear, route_en, busy, tile_pulse, tiles_done, timeout
  );
endinterface

// File: rtl/tile_scheduler.sv
// Descriptor FIFO plus per-tile sequencer (LOAD -> CLEAR -> RUN -> DONE) for the accelerator.
// Optional RUN watchdog enabled by defining TILE_WATCHDOG_EN.
module tile_scheduler #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DESC_DEPTH     = 4,
  parameter int unsigned CLEAR_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input logic             i_clk,
  input logic             i_nrst,
  tile_scheduler_if.slave bus
);
  localparam int unsigned DescW = 8 * ADDR_WIDTH + 2;
  localparam int unsigned PtrW  = $clog2(DESC_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned ClrW  = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  if (DESC_DEPTH < 2 || (DESC_DEPTH & (DESC_DEPTH - 1)) != 0 || CLEAR_CYCLES < 1 ||
      TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("tile_scheduler: illegal parameter value");
  end

  typedef enum logic [2:0] {StIdle, StLoad, StClear, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [DescW-1:0] mem [DESC_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             ready_q;
  logic [DescW-1:0] cfg_q, cfg_d;
  logic [ClrW-1:0]  clr_cnt_q, clr_cnt_d;
  logic             reg_clear_q, route_en_q, busy_q, tile_pulse_q;
  logic [15:0]      tiles_done_q;
  logic             abort_int, push, pop;

`ifdef TILE_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdW-1:0] wd_cnt_q;
  logic           timeout_q, wd_fire;

  // A done sampled in the final watchdog cycle still completes the tile.
  assign wd_fire = (state_q == StRun) && !bus.tile_done &&
                   (wd_cnt_q == WdW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q <= (state_q == StRun) ? wd_cnt_q + 1'b1 : '0;
      if (wd_fire) timeout_q <= 1'b1;
    end
  end

  assign abort_int   = bus.abort | wd_fire;
  assign bus.timeout = timeout_q;
`else
  assign abort_int   = bus.abort;
  assign bus.timeout = 1'b0;
`endif

  assign push = bus.desc_valid & ready_q & ~abort_int;

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    clr_cnt_d = clr_cnt_q;
    pop       = 1'b0;
    case (state_q)
      StIdle:  if (count_q != '0) state_d = StLoad;
      StLoad: begin
        cfg_d     = mem[rd_ptr_q];
        pop       = 1'b1;
        clr_cnt_d = ClrW'(CLEAR_CYCLES - 1);
        state_d   = StClear;
      end
      StClear: begin
        if (clr_cnt_q == '0) state_d = StRun;
        else                 clr_cnt_d = clr_cnt_q - 1'b1;
      end
      StRun:   if (bus.tile_done) state_d = StDone;
      StDone:  state_d = (count_q != '0) ? StLoad : StIdle;
      default: state_d = StIdle;
    endcase
    if (abort_int) begin
      state_d = StIdle;
      cfg_d   = cfg_q;
      pop     = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (abort_int) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= bus.desc;
  end

  // Outputs are registered off next state so they line up with the state they describe.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ready_q      <= 1'b0;
      cfg_q        <= '0;
      clr_cnt_q    <= '0;
      reg_clear_q  <= 1'b0;
      route_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      tile_pulse_q <= 1'b0;
      tiles_done_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ready_q      <= (count_d != CntW'(DESC_DEPTH));
      cfg_q        <= cfg_d;
      clr_cnt_q    <= clr_cnt_d;
      reg_clear_q  <= abort_int | (state_d == StClear);
      route_en_q   <= (state_d == StRun);
      busy_q       <= (state_d != StIdle);
      tile_pulse_q <= (state_d == StDone);
      if (state_d == StDone) tiles_done_q <= tiles_done_q + 16'd1;
    end
  end

  assign bus.desc_ready = ready_q;
  assign bus.desc_count = count_q;
  assign bus.cfg        = cfg_q;
  assign bus.reg_clear  = reg_clear_q;
  assign bus.route_en   = route_en_q;
  assign bus.busy       = busy_q;
  assign bus.tile_pulse = tile_pulse_q;
  assign bus.tiles_done = tiles_done_q;
endmodule

// File: tb/tb_tile_scheduler.sv
// Directed bench for tile_scheduler: single tile, full FIFO, back-to-back tiles, abort,
// ignored done pulses and the watchdog (when TILE_WATCHDOG_EN is defined).
module tb_tile_scheduler;
  localparam int unsigned AW = 8;
  localparam int unsigned D  = 4;

  logic clk;
  logic nrst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n;

  tile_scheduler_if #(.ADDR_WIDTH(AW), .DESC_DEPTH(D)) bus ();

  tile_scheduler #(
    .ADDR_WIDTH    (AW),
    .DESC_DEPTH    (D),
    .CLEAR_CYCLES  (2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk (clk),
    .i_nrst(nrst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push1(input logic [65:0] d);
    bus.desc       = d;
    bus.desc_valid = 1'b1;
    step();
    bus.desc_valid = 1'b0;
  endtask

  task automatic wait_route(input int budget, output int cyc);
    cyc = 0;
    while (bus.route_en !== 1'b1 && cyc < budget) begin
      step();
      cyc++;
    end
    chk("route_en_rise", {127'b0, bus.route_en}, 128'd1);
  endtask

  task automatic finish_tile(input string tag, input logic [65:0] exp);
    chk(tag, {62'b0, bus.cfg}, {62'b0, exp});
    bus.tile_done = 1'b1;
    step();
    bus.tile_done = 1'b0;
    chk("done_pulse", {127'b0, bus.tile_pulse}, 128'd1);
    chk("done_route_low", {127'b0, bus.route_en}, 128'd0);
  endtask

  logic [65:0] tiles [11];

  initial begin
    tiles[0]  = {2'd1, 64'h1122_3344_5566_7788};
    tiles[1]  = {2'd2, 64'h0102_0304_0506_0708};
    tiles[2]  = {2'd3, 64'hA0A1_A2A3_A4A5_A6A7};
    tiles[3]  = {2'd0, 64'hB0B1_B2B3_B4B5_B6B7};
    tiles[4]  = {2'd1, 64'hC0C1_C2C3_C4C5_C6C7};
    tiles[5]  = {2'd2, 64'hD0D1_D2D3_D4D5_D6D7};
    tiles[6]  = {2'd3, 64'hE0E1_E2E3_E4E5_E6E7};
    tiles[7]  = {2'd0, 64'hF0F1_F2F3_F4F5_F6F7};
    tiles[8]  = {2'd1, 64'h1111_2222_3333_4444};
    tiles[9]  = {2'd2, 64'h5555_6666_7777_8888};
    tiles[10] = {2'd3, 64'h9999_AAAA_BBBB_CCCC};

    nrst = 1'b0;
    bus.desc = '0;
    bus.desc_valid = 1'b0;
    bus.tile_done = 1'b0;
    bus.abort = 1'b0;
    step();
    step();
    chk("rst_ready", {127'b0, bus.desc_ready}, 128'd0);
    chk("rst_count", {125'b0, bus.desc_count}, 128'd0);
    chk("rst_cfg", {62'b0, bus.cfg}, 128'd0);
    chk("rst_clear", {127'b0, bus.reg_clear}, 128'd0);
    chk("rst_route", {127'b0, bus.route_en}, 128'd0);
    chk("rst_busy", {127'b0, bus.busy}, 128'd0);
    chk("rst_tiles", {112'b0, bus.tiles_done}, 128'd0);
    chk("rst_timeout", {127'b0, bus.timeout}, 128'd0);
    nrst = 1'b1;
    step();
    chk("ready_after_rst", {127'b0, bus.desc_ready}, 128'd1);

    // Single tile: push at edge k, clear k+2..k+3, route from k+4 for 10 cycles.
    push1(tiles[0]);
    chk("t1_count", {125'b0, bus.desc_count}, 128'd1);
    chk("t1_idle_at_k", {127'b0, bus.busy}, 128'd0);
    step();
    chk("t1_load_busy", {127'b0, bus.busy}, 128'd1);
    chk("t1_load_noclr", {127'b0, bus.reg_clear}, 128'd0);
    step();
    chk("t1_clr0", {127'b0, bus.reg_clear}, 128'd1);
    chk("t1_cfg", {62'b0, bus.cfg}, {62'b0, tiles[0]});
    chk("t1_popped", {125'b0, bus.desc_count}, 128'd0);
    step();
    chk("t1_clr1", {127'b0, bus.reg_clear}, 128'd1);
    chk("t1_route_lo", {127'b0, bus.route_en}, 128'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t1_route_hi", {127'b0, bus.route_en}, 128'd1);
      chk("t1_clr_lo", {127'b0, bus.reg_clear}, 128'd0);
    end
    bus.tile_done = 1'b1;
    step();
    bus.tile_done = 1'b0;
    chk("t1_route_fall", {127'b0, bus.route_en}, 128'd0);
    chk("t1_pulse", {127'b0, bus.tile_pulse}, 128'd1);
    chk("t1_tiles", {112'b0, bus.tiles_done}, 128'd1);
    step();
    chk("t1_pulse_once", {127'b0, bus.tile_pulse}, 128'd0);
    chk("t1_idle", {127'b0, bus.busy}, 128'd0);

    // Fill the FIFO while tile A runs; the 5th push waits for the next LOAD.
    push1(tiles[1]);
    wait_route(20, n);
    chk("t2_latency", n, 128'd4);
    bus.desc_valid = 1'b1;
    for (int i = 2; i < 6; i++) begin
      bus.desc = tiles[i];
      step();
    end
    bus.desc = tiles[6];
    chk("t2_full_count", {125'b0, bus.desc_count}, 128'd4);
    chk("t2_full_ready", {127'b0, bus.desc_ready}, 128'd0);
    step();
    chk("t2_held_count", {125'b0, bus.desc_count}, 128'd4);
    chk("t2_held_ready", {127'b0, bus.desc_ready}, 128'd0);
    finish_tile("t2_cfg_a", tiles[1]);
    step();
    chk("t2_load_count", {125'b0, bus.desc_count}, 128'd4);
    step();
    chk("t2_pop_count", {125'b0, bus.desc_count}, 128'd3);
    chk("t2_pop_ready", {127'b0, bus.desc_ready}, 128'd1);
    step();
    bus.desc_valid = 1'b0;
    chk("t2_fifth_in", {125'b0, bus.desc_count}, 128'd4);
    chk("t2_refull", {127'b0, bus.desc_ready}, 128'd0);

    // Drain: FIFO order, DONE->LOAD without IDLE (route rises 4 cycles after each done).
    wait_route(20, n);
    finish_tile("t3_cfg", tiles[2]);
    for (int i = 3; i < 7; i++) begin
      wait_route(20, n);
      chk("t3_b2b_latency", n, 128'd4);
      finish_tile("t3_cfg", tiles[i]);
    end
    step();
    chk("t3_idle", {127'b0, bus.busy}, 128'd0);
    chk("t3_tiles", {112'b0, bus.tiles_done}, 128'd7);

    // Abort mid-RUN with two queued; push in the abort cycle is dropped.
    push1(tiles[7]);
    wait_route(20, n);
    push1(tiles[8]);
    push1(tiles[9]);
    chk("t4_queued", {125'b0, bus.desc_count}, 128'd2);
    bus.abort = 1'b1;
    bus.desc = tiles[10];
    bus.desc_valid = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.desc_valid = 1'b0;
    chk("t4_idle", {127'b0, bus.busy}, 128'd0);
    chk("t4_flush", {125'b0, bus.desc_count}, 128'd0);
    chk("t4_clr", {127'b0, bus.reg_clear}, 128'd1);
    chk("t4_route", {127'b0, bus.route_en}, 128'd0);
    chk("t4_tiles", {112'b0, bus.tiles_done}, 128'd7);
    chk("t4_cfg_kept", {62'b0, bus.cfg}, {62'b0, tiles[7]});
    step();
    chk("t4_clr_once", {127'b0, bus.reg_clear}, 128'd0);
    chk("t4_still_idle", {127'b0, bus.busy}, 128'd0);
    chk("t4_still_empty", {125'b0, bus.desc_count}, 128'd0);

    // Done outside RUN is ignored; done together with abort is not counted.
    bus.tile_done = 1'b1;
    step();
    bus.tile_done = 1'b0;
    chk("t5_idle_nopulse", {127'b0, bus.tile_pulse}, 128'd0);
    chk("t5_idle_stay", {127'b0, bus.busy}, 128'd0);
    push1(tiles[8]);
    step();
    step();
    chk("t5_clear", {127'b0, bus.reg_clear}, 128'd1);
    bus.tile_done = 1'b1;
    step();
    bus.tile_done = 1'b0;
    chk("t5_clr_nopulse", {127'b0, bus.tile_pulse}, 128'd0);
    step();
    chk("t5_run", {127'b0, bus.route_en}, 128'd1);
    chk("t5_tiles", {112'b0, bus.tiles_done}, 128'd7);
    bus.tile_done = 1'b1;
    bus.abort = 1'b1;
    step();
    bus.tile_done = 1'b0;
    bus.abort = 1'b0;
    chk("t5_abort_nopulse", {127'b0, bus.tile_pulse}, 128'd0);
    chk("t5_abort_idle", {127'b0, bus.busy}, 128'd0);
    step();
    chk("t5_abort_tiles", {112'b0, bus.tiles_done}, 128'd7);
    chk("t5_abort_nolate", {127'b0, bus.tile_pulse}, 128'd0);

`ifdef TILE_WATCHDOG_EN
    // Watchdog: 16 RUN cycles without done -> sticky timeout and abort.
    push1(tiles[9]);
    wait_route(20, n);
    for (int i = 0; i < 15; i++) step();
    chk("t6_pre_timeout", {127'b0, bus.timeout}, 128'd0);
    chk("t6_pre_route", {127'b0, bus.route_en}, 128'd1);
    step();
    chk("t6_timeout", {127'b0, bus.timeout}, 128'd1);
    chk("t6_idle", {127'b0, bus.busy}, 128'd0);
    chk("t6_clr", {127'b0, bus.reg_clear}, 128'd1);
    chk("t6_tiles", {112'b0, bus.tiles_done}, 128'd7);
    for (int i = 0; i < 5; i++) step();
    chk("t6_sticky", {127'b0, bus.timeout}, 128'd1);
`else
    // No watchdog: RUN waits indefinitely.
    push1(tiles[9]);
    wait_route(20, n);
    for (int i = 0; i < 40; i++) step();
    chk("t6_no_timeout", {127'b0, bus.timeout}, 128'd0);
    chk("t6_still_run", {127'b0, bus.route_en}, 128'd1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("t6_abort_idle", {127'b0, bus.busy}, 128'd0);
`endif

    nrst = 1'b0;
    step();
    chk("end_rst_timeout", {127'b0, bus.timeout}, 128'd0);
    chk("end_rst_tiles", {112'b0, bus.tiles_done}, 128'd0);
    chk("end_rst_cfg", {62'b0, bus.cfg}, 128'd0);
    chk("end_rst_ready", {127'b0, bus.desc_ready}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
